// File: rtl/vmm_row_mac.sv
// vmm_row_mac: reads one VEC_LEN-element vector x from the upstream input FIFO
// and computes y[r] = sum_c W[r][c]*x[c] for every row r, one signed MAC per
// cycle. It streams the ROWS results out over a valid/ready port. W is a
// register file that can only be written while the block is idle.
//
// Ports:
//   Clk, Rst_n            clock (rising edge), async active-low reset
//   Start                 1-cycle pulse that starts one vector (IDLE only)
//   fifo_data/empty/rd    FIFO read side; fifo_rd is combinational
//   w_we/w_addr/w_data    weight write, index = r*VEC_LEN + c (IDLE only)
//   res_valid/ready       result handshake
//   res_data/res_idx      signed y[r] and its row index r
//   busy                  high in every state except IDLE
//   done                  1-cycle pulse after the last result is accepted
module vmm_row_mac #(
  parameter int DATA_W  = 16,
  parameter int VEC_LEN = 4,
  parameter int ROWS    = 4,
  localparam int ACC_W  = 2 * DATA_W + $clog2(VEC_LEN),
  localparam int WA_W   = $clog2(ROWS * VEC_LEN),
  localparam int RI_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic              w_we,
  input  logic [WA_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [RI_W-1:0]   res_idx,
  output logic              busy,
  output logic              done
);

  // The column counter needs one extra bit so that it can hold VEC_LEN.
  localparam int CW = $clog2(VEC_LEN + 1);
  localparam int CI = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_OUT, S_FIN} state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             col_q, col_d;
  logic [RI_W-1:0]           row_q, row_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  w_q [ROWS*VEC_LEN];
  logic signed [DATA_W-1:0]  x_q [VEC_LEN];

  logic                      w_wr;
  logic                      x_wr;
  logic [CI-1:0]             col_i;
  logic [WA_W-1:0]           w_idx;
  logic signed [2*DATA_W-1:0] prod;

  assign col_i = col_q[CI-1:0];
  assign w_idx = WA_W'(row_q) * WA_W'(VEC_LEN) + WA_W'(col_i);
  assign prod  = w_q[w_idx] * x_q[col_i];

  assign res_valid = (state_q == S_OUT);
  assign res_data  = acc_q;
  assign res_idx   = row_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign fifo_rd   = (state_q == S_LOAD) && !fifo_empty && (col_q < CW'(VEC_LEN));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    acc_d   = acc_q;
    w_wr    = 1'b0;
    x_wr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        w_wr = w_we;
        if (Start) begin
          state_d = S_LOAD;
          col_d   = '0;
        end
      end
      S_LOAD: begin
        if (fifo_rd) begin
          x_wr  = 1'b1;
          col_d = col_q + 1'b1;
          // Leave LOAD on the edge of the last pop, so that exactly VEC_LEN
          // elements are taken from the FIFO.
          if (col_q == CW'(VEC_LEN - 1)) begin
            state_d = S_MAC;
            col_d   = '0;
            row_d   = '0;
            acc_d   = '0;
          end
        end
      end
      S_MAC: begin
        // The size cast sign-extends the full-precision product.
        acc_d = acc_q + ACC_W'(prod);
        col_d = col_q + 1'b1;
        if (col_q == CW'(VEC_LEN - 1)) begin
          state_d = S_OUT;
          col_d   = '0;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          if (row_q == RI_W'(ROWS - 1)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_MAC;
            row_d   = row_q + 1'b1;
            col_d   = '0;
            acc_d   = '0;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      for (int unsigned i = 0; i < unsigned'(ROWS * VEC_LEN); i++) w_q[i[WA_W-1:0]] <= '0;
      for (int unsigned i = 0; i < unsigned'(VEC_LEN); i++) x_q[i[CI-1:0]] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      if (w_wr) w_q[w_addr] <= w_data;
      if (x_wr) x_q[col_i] <= fifo_data;
    end
  end

endmodule

// File: tb/tb_vmm_row_mac.sv
module tb_vmm_row_mac;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        w_we = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [15:0] w_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [33:0] res_data;
  logic [1:0]  res_idx;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  // FIFO model: the pop is an NBA at the same edge where the DUT samples data.
  logic [15:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_count = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fifo_mem[rd_ptr[5:0]];

  // Results collected by run_vector.
  logic [33:0] got_data [0:7];
  logic [1:0]  got_idx [0:7];
  int n_got, done_after, lat, bad_rd, stable_bad, rd_start;
  bit timed_out;

  vmm_row_mac #(.DATA_W(16), .VEC_LEN(4), .ROWS(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (fifo_rd) begin
      rd_ptr   <= rd_ptr + 1;
      rd_count <= rd_count + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [15:0] v);
    fifo_mem[wr_ptr[5:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic write_w(input int a, input logic [15:0] v);
    @(negedge Clk);
    w_we = 1'b1; w_addr = a[3:0]; w_data = v;
    @(negedge Clk);
    w_we = 1'b0;
  endtask

  task automatic load_identity();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        write_w(r * 4 + c, (r == c) ? 16'd1 : 16'd0);
  endtask

  // Pulses Start and then runs until done (or a 300-cycle budget). hold = number
  // of OUT cycles for which res_ready is kept low; inj = loop cycle in which
  // Start and w_we (W[0]=9) are pulsed, 0 for none.
  task automatic run_vector(input int hold, input int inj);
    int h;
    bit hs;
    logic [33:0] hd;
    logic [1:0] hi;
    h = hold; hs = 0; hd = '0; hi = '0;
    n_got = 0; done_after = -1; lat = 0; timed_out = 1; bad_rd = 0; stable_bad = 0;
    rd_start = rd_count;
    res_ready = (hold == 0);
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (k == inj) begin
        Start = 1'b1; w_we = 1'b1; w_addr = 4'd0; w_data = 16'd9;
      end else if (k == inj + 1) begin
        Start = 1'b0; w_we = 1'b0;
      end
      if (fifo_rd && fifo_empty) bad_rd++;
      if (done) begin
        done_after = n_got; lat = k; timed_out = 0;
        break;
      end
      if (res_valid) begin
        if (h > 0) begin
          if (hs && (res_data !== hd || res_idx !== hi)) stable_bad++;
          hs = 1; hd = res_data; hi = res_idx;
          h--;
          res_ready = 1'b0;
        end else begin
          if (hs && (res_data !== hd || res_idx !== hi)) stable_bad++;
          hs = 0;
          res_ready = 1'b1;
          if (n_got < 8) begin
            got_data[n_got] = res_data;
            got_idx[n_got]  = res_idx;
          end
          n_got++;
        end
      end
      @(negedge Clk);
    end
    Start = 1'b0; w_we = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd: got %b expected 0", fifo_rd); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (res_data !== 34'd0 || res_idx !== 2'd0) begin
      errors++; $display("FAIL reset_data: got %0h/%0d expected 0/0", res_data, res_idx);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_identity();
    logic signed [33:0] e [4];
    e = '{34'sd5, -34'sd3, 34'sd7, 34'sd100};
    load_identity();
    push(16'd5); push(-16'sd3); push(16'd7); push(16'd100); push(16'd999);
    run_vector(0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL ident_timeout: got no done expected done"); end
    checks++; if (n_got != 4) begin errors++; $display("FAIL ident_count: got %0d expected 4", n_got); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_idx[i] !== 2'(i) || got_data[i] !== e[i]) begin
        errors++; $display("FAIL ident_res%0d: got (%0d,%0d) expected (%0d,%0d)", i, got_idx[i], $signed(got_data[i]), i, e[i]);
      end
    end
    checks++; if (done_after != 4) begin errors++; $display("FAIL ident_done_order: got %0d expected 4", done_after); end
    checks++; if (rd_count - rd_start != 4) begin errors++; $display("FAIL ident_pops: got %0d expected 4", rd_count - rd_start); end
    checks++; if (lat != 25) begin errors++; $display("FAIL ident_latency: got %0d expected 25", lat); end
    checks++; if (bad_rd != 0) begin errors++; $display("FAIL ident_rd_empty: got %0d expected 0", bad_rd); end
    wr_ptr = wr_ptr - 1;  // discard the unpopped extra element
  endtask

  task automatic test_extreme();
    for (int a = 0; a < 16; a++) write_w(a, 16'h7FFF);
    for (int i = 0; i < 4; i++) push(16'h8000);
    run_vector(0, 0);
    checks++; if (timed_out || n_got != 4) begin errors++; $display("FAIL ext_count: got %0d expected 4", n_got); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_idx[i] !== 2'(i) || got_data[i] !== 34'h3_0002_0000) begin
        errors++; $display("FAIL ext_res%0d: got (%0d,%0h) expected (%0d,300020000)", i, got_idx[i], got_data[i], i);
      end
    end
  endtask

  task automatic test_fifo_stall();
    logic signed [33:0] e [4];
    e = '{34'sd5, -34'sd3, 34'sd7, 34'sd100};
    load_identity();
    fork
      run_vector(0, 0);
      begin
        repeat (7) @(negedge Clk);
        push(16'd5);
        repeat (3) @(negedge Clk);
        push(-16'sd3);
        repeat (3) @(negedge Clk);
        push(16'd7);
        repeat (3) @(negedge Clk);
        push(16'd100);
      end
    join
    checks++; if (timed_out || n_got != 4) begin errors++; $display("FAIL stall_count: got %0d expected 4", n_got); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_idx[i] !== 2'(i) || got_data[i] !== e[i]) begin
        errors++; $display("FAIL stall_res%0d: got (%0d,%0d) expected (%0d,%0d)", i, got_idx[i], $signed(got_data[i]), i, e[i]);
      end
    end
    checks++; if (bad_rd != 0) begin errors++; $display("FAIL stall_rd_empty: got %0d expected 0", bad_rd); end
    checks++; if (rd_count - rd_start != 4) begin errors++; $display("FAIL stall_pops: got %0d expected 4", rd_count - rd_start); end
    checks++; if (lat <= 25) begin errors++; $display("FAIL stall_latency: got %0d expected >25", lat); end
  endtask

  task automatic test_backpressure();
    push(16'd1); push(16'd2); push(16'd3); push(16'd4);
    run_vector(10, 0);
    checks++; if (timed_out || n_got != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", n_got); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_idx[i] !== 2'(i) || got_data[i] !== 34'(i + 1)) begin
        errors++; $display("FAIL bp_res%0d: got (%0d,%0d) expected (%0d,%0d)", i, got_idx[i], got_data[i], i, i + 1);
      end
    end
    checks++; if (stable_bad != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", stable_bad); end
    checks++; if (done_after != 4) begin errors++; $display("FAIL bp_done_order: got %0d expected 4", done_after); end
  endtask

  task automatic test_ignored_inputs();
    int extra;
    push(16'd2); push(16'd4); push(16'd6); push(16'd8);
    run_vector(0, 6);
    checks++; if (timed_out || n_got != 4) begin errors++; $display("FAIL ign_count: got %0d expected 4", n_got); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== 34'(2 * i + 2)) begin
        errors++; $display("FAIL ign_res%0d: got %0d expected %0d", i, got_data[i], 2 * i + 2);
      end
    end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) extra++;
      @(negedge Clk);
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ign_no_restart: got %0d busy/done cycles expected 0", extra); end
    push(16'd1); push(16'd1); push(16'd1); push(16'd1);
    run_vector(0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== 34'd1) begin
        errors++; $display("FAIL ign_oldw%0d: got %0d expected 1", i, got_data[i]);
      end
    end
  endtask

  task automatic test_reset_mid_mac();
    load_identity();
    push(16'd11); push(16'd12); push(16'd13); push(16'd14);
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
    repeat (5) @(negedge Clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    #2 Rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || fifo_rd !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: got busy=%b valid=%b rd=%b done=%b expected all 0", busy, res_valid, fifo_rd, done);
    end
    @(negedge Clk) Rst_n = 1'b1;
    push(16'd1); push(16'd2); push(16'd3); push(16'd4);
    run_vector(0, 0);
    checks++; if (timed_out || n_got != 4) begin errors++; $display("FAIL midrst_count: got %0d expected 4", n_got); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_idx[i] !== 2'(i) || got_data[i] !== 34'd0) begin
        errors++; $display("FAIL midrst_w0_%0d: got (%0d,%0d) expected (%0d,0)", i, got_idx[i], got_data[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_extreme();
    test_fifo_stall();
    test_backpressure();
    test_ignored_inputs();
    test_reset_mid_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
